// File: rtl/mem_if_pkg.sv
// Shared definitions for the MA-stage data-memory responder.
//   - state encodings for the responder FSM
//   - data word width and latency counter width
//   - address-error check shared by any block that decodes a byte address
package mem_if_pkg;

  localparam int WORD_W    = 32;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

  // A byte address is bad when it is not word aligned or when any bit above
  // the word-index field is set (beyond the array capacity).
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned       addr_w);
    logic [WORD_W-1:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dm_sync_ram.sv
// Single-port word array with synchronous write and synchronous read.
// Ports:
//   clk   - rising-edge clock
//   en    - access enable for this edge
//   we    - 1 = write wdata at addr, 0 = read addr into rdata
//   addr  - word index
//   wdata - write data
//   rdata - registered read data, updated only by an enabled read
// The array and the read register have no reset: contents survive a
// controller reset.
module dm_sync_ram
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the MA-stage data-memory interface. Accepts one load/store
// at a time, waits LATENCY cycles, then pulses resp_valid with load data.
// stall freezes the pipeline while an access is in flight.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request, nothing outstanding
// WAIT  | request latched, counting down remaining latency
// RESP  | access committed, resp_valid high; may accept the next request
//
// Ports:
//   clk, reset                      - clock, async active-high reset
//   req_valid/req_we/req_addr/req_wdata - request from MA stage
//   req_ready                       - request accepted when valid & ready
//   resp_valid/resp_rdata/resp_err  - one-cycle completion
//   stall                           - pipeline freeze
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  // Counter load on acceptance: WAIT cycles still to run after the first one.
  localparam int                   LAT_M2   = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LAT_M2);

  dm_state_t             state, state_nxt;
  logic [LAT_CNT_W-1:0]  cnt, cnt_nxt;

  logic                  lat_we;
  logic [ADDR_W-1:0]     lat_idx;
  logic [WORD_W-1:0]     lat_wdata;
  logic                  lat_err;

  logic                  accept;
  logic [ADDR_W-1:0]     req_idx;
  logic                  req_err;

  logic                  commit;
  logic                  c_we;
  logic [ADDR_W-1:0]     c_idx;
  logic [WORD_W-1:0]     c_wdata;
  logic                  c_err;

  logic                  ram_en;
  logic [WORD_W-1:0]     ram_rdata;

  assign req_idx = req_addr[ADDR_W+1:2];
  assign req_err = addr_err(req_addr, ADDR_W);

  assign req_ready = (state != DM_WAIT);
  assign accept    = req_valid & req_ready;

  // Held low during reset so a request on the bus cannot freeze the pipeline
  // while the controller is being cleared.
  assign stall = ~reset & ((state == DM_WAIT) | accept);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_err   <= 1'b0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_idx   <= req_idx;
      lat_wdata <= req_wdata;
      lat_err   <= req_err;
    end
  end

  // Commit happens on the edge that enters RESP. With LATENCY==1 that is the
  // accepting edge itself, so the array is fed straight from the request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    c_we      = lat_we;
    c_idx     = lat_idx;
    c_wdata   = lat_wdata;
    c_err     = lat_err;
    case (state)
      DM_IDLE, DM_RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = DM_RESP;
            commit    = 1'b1;
            c_we      = req_we;
            c_idx     = req_idx;
            c_wdata   = req_wdata;
            c_err     = req_err;
          end else begin
            state_nxt = DM_WAIT;
            cnt_nxt   = LAT_INIT;
          end
        end else begin
          state_nxt = DM_IDLE;
        end
      end
      DM_WAIT: begin
        if (cnt == '0) begin
          state_nxt = DM_RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = DM_IDLE;
      end
    endcase
  end

  // The array has no reset, so its enable is gated by reset directly to keep
  // a held request from touching it while the controller is cleared.
  assign ram_en = commit & ~c_err & ~reset;

  dm_sync_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (c_we),
    .addr  (c_idx),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  // lat_* still describe the access being answered throughout the RESP cycle.
  assign resp_valid = (state == DM_RESP);
  assign resp_err   = resp_valid & lat_err;
  assign resp_rdata = (resp_valid && !lat_we && !lat_err) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic        stall      [3];

  int          lat_of [3] = '{2, 1, 15};
  logic [31:0] model_mem [3][1024];
  exp_t        sb [$];

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .stall(stall[0]));

  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .stall(stall[1]));

  data_mem_responder #(.ADDR_W(10), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[2]), .req_we(req_we[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .req_ready(req_ready[2]), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .stall(stall[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int s, input string tag);
    chk({tag, "_ready"}, 32'(req_ready[s]), 32'd1);
    chk({tag, "_rvalid"}, 32'(resp_valid[s]), 32'd0);
    chk({tag, "_rdata"}, resp_rdata[s], 32'd0);
    chk({tag, "_err"}, 32'(resp_err[s]), 32'd0);
    chk({tag, "_stall"}, 32'(stall[s]), 32'd0);
  endtask

  // Present a request in the current cycle and push its expected response.
  task automatic issue(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd);
    exp_t e;
    logic err;
    int   idx;
    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wd;
    #1;
    chk("req_ready", 32'(req_ready[s]), 32'd1);
    chk("stall_accept", 32'(stall[s]), 32'd1);
    err     = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
    idx     = int'(addr[11:2]);
    e.err   = err;
    e.rdata = 32'd0;
    if (!err) begin
      if (we) model_mem[s][idx] = wd;
      else    e.rdata = model_mem[s][idx];
    end
    sb.push_back(e);
  endtask

  // Follow an accepted request to its response; returns inside the RESP cycle.
  // hold=1 keeps req_valid asserted with a changing address through WAIT.
  task automatic wait_resp(input int s, input logic hold, input string tag);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      n++;
      if (hold && n < lat_of[s]) begin
        req_valid[s] = 1'b1;
        req_addr[s]  = 32'h30 + 32'(4 * n);
      end else begin
        req_valid[s] = 1'b0;
      end
      #1;
      if (!resp_valid[s]) begin
        chk({tag, "_stall_wait"}, 32'(stall[s]), 32'd1);
        if (hold) chk({tag, "_ready_wait"}, 32'(req_ready[s]), 32'd0);
      end
    end while (!resp_valid[s] && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(lat_of[s]));
    chk({tag, "_resp_valid"}, 32'(resp_valid[s]), 32'd1);
    e = sb.pop_front();
    if (resp_valid[s]) begin
      chk({tag, "_rdata"}, resp_rdata[s], e.rdata);
      chk({tag, "_err"}, 32'(resp_err[s]), 32'(e.err));
      chk({tag, "_stall_resp"}, 32'(stall[s]), 32'd0);
    end
  endtask

  task automatic do_req(input int s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    @(negedge clk);
    issue(s, we, addr, wd);
    wait_resp(s, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk_idle(0, "rst_l2");
    chk_idle(1, "rst_l1");
    chk_idle(2, "rst_l15");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_idle(0, "post_rst");

    // Basic store then load, LATENCY=2
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, "st10");
    do_req(0, 1'b0, 32'h10, 32'h0, "ld10");

    // Back-to-back read-after-write: load presented in the store's RESP cycle
    do_req(0, 1'b1, 32'h20, 32'h55, "b2b_st");
    issue(0, 1'b0, 32'h20, 32'h0);
    wait_resp(0, 1'b0, "b2b_ld");

    // Error accesses
    do_req(0, 1'b1, 32'h0, 32'hCAFE0000, "st0");
    do_req(0, 1'b0, 32'h13, 32'h0, "ld_misal");
    do_req(0, 1'b1, 32'h4000, 32'h12345678, "st_range");
    do_req(0, 1'b0, 32'h0, 32'h0, "ld0_after");

    // Latency extremes
    do_req(1, 1'b1, 32'h40, 32'hA1A1A1A1, "l1_st");
    do_req(1, 1'b0, 32'h40, 32'h0, "l1_ld");
    issue(1, 1'b0, 32'h40, 32'h0);
    wait_resp(1, 1'b0, "l1_b2b");
    do_req(2, 1'b1, 32'h44, 32'hF00DF00D, "l15_st");
    do_req(2, 1'b0, 32'h44, 32'h0, "l15_ld");

    // Reset pulsed during WAIT of an uncommitted store
    do_req(0, 1'b1, 32'h8, 32'h11111111, "st8");
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h8;
    req_wdata[0] = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    chk("pre_rst_stall", 32'(stall[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk_idle(0, "mid_rst");
    @(negedge clk);
    reset = 1'b0;
    do_req(0, 1'b0, 32'h8, 32'h0, "ld8_after_rst");

    // Request held during WAIT with a changing address
    do_req(2, 1'b1, 32'h30, 32'h0000AAAA, "hold_st30");
    do_req(2, 1'b1, 32'h34, 32'h0000BBBB, "hold_st34");
    @(negedge clk);
    issue(2, 1'b0, 32'h30, 32'h0);
    wait_resp(2, 1'b1, "hold_ld");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("hold_no_second", 32'(resp_valid[2]), 32'd0);
    end
    do_req(2, 1'b0, 32'h34, 32'h0, "hold_ld34");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
